lbp_engine: RTL and testbench

Parametrised Local Binary Pattern engine: scans a 2^ROW_BITS x 2^COL_BITS grayscale image from the gray memory, computes one 8-bit LBP code per pixel with a programmable threshold, and streams codes to the LBP memory over a valid/ready handshake. Compared with the fixed 128x128 engine, it adds configurable image and pixel size, a border-replicate mode that codes every pixel, and output backpressure. It sits between the gray-image ROM and the LBP result RAM, and is started by `gray_ready`.

---
 rtl/lbp_engine_if.sv | 38 +++
 rtl/lbp_engine.sv | 145 ++++++++++++++
 tb/tb_lbp_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_engine_if.sv
// Bus bundle for the LBP engine: gray-image fetch port, frame control and
// the LBP result stream.
//
// Handshake: lbp_valid/lbp_ready follow strict valid/ready rules. A code
// transfers on a rising edge where both are high; once lbp_valid rises,
// lbp_addr/lbp_data hold steady and lbp_valid stays high until that
// transfer. lbp_ready may be high before lbp_valid and does not have to wait
// for it. The gray port has no handshake: gray_data answers gray_addr
// combinationally in the same cycle that gray_req is high.
interface lbp_engine_if #(
    parameter int ROW_BITS = 7,
    parameter int COL_BITS = 7,
    parameter int PIX_W    = 8
);
    localparam int AW = ROW_BITS + COL_BITS;

    logic             gray_ready;
    logic             gray_req;
    logic [AW-1:0]    gray_addr;
    logic [PIX_W-1:0] gray_data;
    logic             border_mode;
    logic [PIX_W-1:0] thresh;
    logic             lbp_valid;
    logic             lbp_ready;
    logic [AW-1:0]    lbp_addr;
    logic [7:0]       lbp_data;
    logic             finish;

    modport master (
        input  gray_ready, gray_data, border_mode, thresh, lbp_ready,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, gray_data, border_mode, thresh, lbp_ready,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface

// File: rtl/lbp_engine.sv
// Local Binary Pattern engine. For each pixel it fetches the centre and its
// eight neighbours one per cycle, builds the code MSB-first and offers it on
// a valid/ready stream. border_mode=1 codes every pixel with clamped
// (replicated) neighbours; border_mode=0 codes only the interior.
module lbp_engine #(
    parameter int ROW_BITS = 7,
    parameter int COL_BITS = 7,
    parameter int PIX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    lbp_engine_if.master     bus,
    output logic [3:0]       dbg_state
);
    typedef enum logic [3:0] {
        IDLE, CUR, N7, N6, N5, N4, N3, N2, N1, N0, OUT
    } state_t;

    localparam logic [ROW_BITS-1:0] ROW_MAX = {ROW_BITS{1'b1}};
    localparam logic [ROW_BITS-1:0] ROW_IN  = {{(ROW_BITS-1){1'b1}}, 1'b0};
    localparam logic [COL_BITS-1:0] COL_MAX = {COL_BITS{1'b1}};
    localparam logic [COL_BITS-1:0] COL_IN  = {{(COL_BITS-1){1'b1}}, 1'b0};

    state_t              state;
    logic                mode_r;
    logic [PIX_W-1:0]    thresh_r;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic [PIX_W-1:0]    center;
    logic [7:0]          code;

    logic [ROW_BITS-1:0] row_p, row_m, nbr_row;
    logic [COL_BITS-1:0] col_p, col_m, nbr_col;
    logic                fetch;
    logic                nbr_bit;
    logic [7:0]          code_next;
    logic [ROW_BITS-1:0] row_last;
    logic [COL_BITS-1:0] col_last, col_first;
    logic                last_pix;

    assign dbg_state = state;

    // Clamped neighbour coordinates; clamping never triggers in interior mode.
    assign row_p = (row == ROW_MAX) ? row : row + 1'b1;
    assign row_m = (row == '0)      ? row : row - 1'b1;
    assign col_p = (col == COL_MAX) ? col : col + 1'b1;
    assign col_m = (col == '0)      ? col : col - 1'b1;

    // Scan window bounds for the latched mode.
    assign row_last  = mode_r ? ROW_MAX : ROW_IN;
    assign col_last  = mode_r ? COL_MAX : COL_IN;
    assign col_first = mode_r ? '0 : {{(COL_BITS-1){1'b0}}, 1'b1};
    assign last_pix  = (row == row_last) && (col == col_last);

    // Comparison at PIX_W+1 bits so centre+thresh cannot wrap.
    assign nbr_bit   = ({1'b0, bus.gray_data} >= ({1'b0, center} + {1'b0, thresh_r}));
    assign code_next = {code[6:0], nbr_bit};

    // Fetch address decode from the current state and pixel position.
    always_comb begin
        nbr_row = row;
        nbr_col = col;
        case (state)
            N7: begin nbr_row = row_p; nbr_col = col_p; end
            N6: begin nbr_row = row_p;                  end
            N5: begin nbr_row = row_p; nbr_col = col_m; end
            N4: begin                  nbr_col = col_p; end
            N3: begin                  nbr_col = col_m; end
            N2: begin nbr_row = row_m; nbr_col = col_p; end
            N1: begin nbr_row = row_m;                  end
            N0: begin nbr_row = row_m; nbr_col = col_m; end
            default: ;
        endcase
        fetch         = (state != IDLE) && (state != OUT);
        bus.gray_req  = fetch;
        bus.gray_addr = fetch ? {nbr_row, nbr_col} : '0;
    end

    // Frame sequencer: per-pixel fetch sequence, code assembly and output hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mode_r        <= 1'b0;
            thresh_r      <= '0;
            row           <= '0;
            col           <= '0;
            center        <= '0;
            code          <= '0;
            bus.lbp_valid <= 1'b0;
            bus.lbp_addr  <= '0;
            bus.lbp_data  <= '0;
            bus.finish    <= 1'b0;
        end else begin
            bus.finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.gray_ready) begin
                        mode_r   <= bus.border_mode;
                        thresh_r <= bus.thresh;
                        row      <= bus.border_mode ? '0 : {{(ROW_BITS-1){1'b0}}, 1'b1};
                        col      <= bus.border_mode ? '0 : {{(COL_BITS-1){1'b0}}, 1'b1};
                        state    <= CUR;
                    end
                end
                CUR: begin
                    center <= bus.gray_data;
                    code   <= '0;
                    state  <= N7;
                end
                N7: begin code <= code_next; state <= N6; end
                N6: begin code <= code_next; state <= N5; end
                N5: begin code <= code_next; state <= N4; end
                N4: begin code <= code_next; state <= N3; end
                N3: begin code <= code_next; state <= N2; end
                N2: begin code <= code_next; state <= N1; end
                N1: begin code <= code_next; state <= N0; end
                N0: begin
                    code          <= code_next;
                    bus.lbp_valid <= 1'b1;
                    bus.lbp_data  <= code_next;
                    bus.lbp_addr  <= {row, col};
                    state         <= OUT;
                end
                OUT: begin
                    if (bus.lbp_ready) begin
                        bus.lbp_valid <= 1'b0;
                        if (last_pix) begin
                            bus.finish <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            if (col == col_last) begin
                                col <= col_first;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                            state <= CUR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lbp_engine.sv
// Directed bench for lbp_engine on an 8x8 image. A plain LBP model computes
// the expected code stream for each frame; a compare process checks every
// accepted code against it.
module tb_lbp_engine;
    localparam int RB = 3;
    localparam int CB = 3;
    localparam int PW = 8;
    localparam int AW = RB + CB;
    localparam int H  = 1 << RB;
    localparam int W  = 1 << CB;
    localparam int EW = AW + 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dbg_state;

    lbp_engine_if #(.ROW_BITS(RB), .COL_BITS(CB), .PIX_W(PW)) bus ();

    lbp_engine #(.ROW_BITS(RB), .COL_BITS(CB), .PIX_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- image memory ----------------
    logic [PW-1:0] mem [H*W];
    assign bus.gray_data = mem[bus.gray_addr];

    // ---------------- bookkeeping ----------------
    int             n_checks = 0;
    int             n_pass   = 0;
    logic [EW-1:0]  exp_q[$];
    int             frame_acc = 0;
    int             fin_cnt   = 0;
    logic [AW-1:0]  first_addr;
    logic [7:0]     dut_codes [H*W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- model ----------------
    // bit b of the code -> neighbour offset; bit0 = (-1,-1) ... bit7 = (+1,+1)
    function automatic logic [7:0] model_code(input int r, input int c, input bit m, input int th);
        int dr [8];
        int dc [8];
        int nr, nc;
        logic [7:0] res;
        dr = '{-1, -1, -1,  0, 0,  1, 1, 1};
        dc = '{-1,  0,  1, -1, 1, -1, 0, 1};
        res = '0;
        for (int b = 0; b < 8; b++) begin
            nr = r + dr[b];
            nc = c + dc[b];
            if (m) begin
                if (nr < 0) nr = 0;
                if (nr > H-1) nr = H-1;
                if (nc < 0) nc = 0;
                if (nc > W-1) nc = W-1;
            end
            res[b] = (int'(mem[nr*W+nc]) >= int'(mem[r*W+c]) + th);
        end
        return res;
    endfunction

    task automatic build_expected(input bit m, input int th);
        int lo_r, hi_r, lo_c, hi_c;
        lo_r = m ? 0 : 1;  hi_r = m ? H-1 : H-2;
        lo_c = m ? 0 : 1;  hi_c = m ? W-1 : W-2;
        exp_q.delete();
        for (int r = lo_r; r <= hi_r; r++)
            for (int c = lo_c; c <= hi_c; c++)
                exp_q.push_back({AW'(r*W+c), model_code(r, c, m, th)});
    endtask

    task automatic fill_flat(input logic [7:0] v);
        for (int i = 0; i < H*W; i++) mem[i] = v;
    endtask

    task automatic fill_gradient();
        for (int i = 0; i < H*W; i++) mem[i] = 8'(i);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!reset && bus.finish) fin_cnt++;
        if (!reset && bus.lbp_valid && bus.lbp_ready) begin
            if (frame_acc == 0) first_addr = bus.lbp_addr;
            frame_acc++;
            dut_codes[bus.lbp_addr] = bus.lbp_data;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected code: got addr 0x%0h data 0x%0h, expected none",
                         bus.lbp_addr, bus.lbp_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.lbp_addr, bus.lbp_data} === e) n_pass++;
                else $display("FAIL code stream: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                              bus.lbp_addr, bus.lbp_data, e[EW-1:8], e[7:0]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic start_frame(input bit m, input logic [7:0] th);
        build_expected(m, int'(th));
        frame_acc = 0;
        bus.border_mode = m;
        bus.thresh = th;
        bus.gray_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.gray_ready = 1'b0;
        // mid-frame changes must be ignored
        bus.border_mode = ~m;
        bus.thresh = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_finish(output int cyc);
        int f0;
        f0 = fin_cnt;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!bus.finish && cyc < 5000);
        check("finish pulse seen", 32'(bus.finish), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("finish one cycle", 32'(bus.finish), 32'd0);
        check("finish count", 32'(fin_cnt - f0), 32'd1);
        check("expected queue drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc, n;
        logic [AW-1:0] h_addr;
        logic [7:0] h_data;

        reset = 1'b1;
        bus.gray_ready = 1'b0;
        bus.border_mode = 1'b0;
        bus.thresh = '0;
        bus.lbp_ready = 1'b1;
        fill_flat(8'h40);

        @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              {bus.gray_req, bus.gray_addr, bus.lbp_valid, bus.lbp_addr, bus.lbp_data, bus.finish},
              32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // flat 0x40, thresh 0 -> all 0xFF, 360 cycles
        check("model flat th0", 32'(model_code(3, 3, 1'b0, 0)), 32'hFF);
        start_frame(1'b0, 8'd0);
        wait_finish(cyc);
        check("flat th0 cycles", 32'(cyc), 32'd360);
        check("flat th0 count", 32'(frame_acc), 32'd36);
        check("flat th0 first addr", 32'(first_addr), 32'd9);
        check("flat th0 code", 32'(dut_codes[9]), 32'hFF);

        // flat 0x40, thresh 1 -> all 0x00
        check("model flat th1", 32'(model_code(3, 3, 1'b0, 1)), 32'h00);
        start_frame(1'b0, 8'd1);
        wait_finish(cyc);
        check("flat th1 code", 32'(dut_codes[54]), 32'h00);

        // gradient, interior -> 0xF0
        fill_gradient();
        check("model grad interior", 32'(model_code(3, 4, 1'b0, 0)), 32'hF0);
        start_frame(1'b0, 8'd0);
        wait_finish(cyc);
        check("grad interior (1,1)", 32'(dut_codes[9]), 32'hF0);
        check("grad interior (6,6)", 32'(dut_codes[54]), 32'hF0);

        // gradient, border replicate -> 64 codes
        check("model grad (7,7)", 32'(model_code(7, 7, 1'b1, 0)), 32'hD0);
        start_frame(1'b1, 8'd0);
        wait_finish(cyc);
        check("border count", 32'(frame_acc), 32'd64);
        check("border first addr", 32'(first_addr), 32'd0);
        check("border (0,0)", 32'(dut_codes[0]), 32'hFF);
        check("border (7,7)", 32'(dut_codes[63]), 32'hD0);
        check("border (0,7)", 32'(dut_codes[7]), 32'(model_code(0, 7, 1'b1, 0)));

        // backpressure on the first code
        bus.lbp_ready = 1'b0;
        start_frame(1'b0, 8'd0);
        n = 0;
        @(negedge clk);
        while (!bus.lbp_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("bp valid rises", 32'(bus.lbp_valid), 32'd1);
        h_addr = bus.lbp_addr;
        h_data = bus.lbp_data;
        check("bp held addr", 32'(h_addr), 32'd9);
        check("bp held data", 32'(h_data), 32'hF0);
        for (int i = 0; i < 5; i++) begin
            check("bp hold", {bus.lbp_valid, bus.lbp_addr, bus.lbp_data, bus.gray_req},
                  {1'b1, h_addr, h_data, 1'b0});
            @(posedge clk);
            if (i < 4) @(negedge clk);
        end
        #1 bus.lbp_ready = 1'b1;
        @(negedge clk);
        check("bp 6th cycle", {bus.lbp_valid, bus.lbp_addr, bus.lbp_data},
              {1'b1, h_addr, h_data});
        wait_finish(cyc);
        check("bp count", 32'(frame_acc), 32'd36);

        // saturation: centre 0xFF + thresh 1 -> 0x00
        fill_flat(8'hFF);
        check("model saturation", 32'(model_code(2, 2, 1'b0, 1)), 32'h00);
        start_frame(1'b0, 8'd1);
        wait_finish(cyc);
        check("saturation code", 32'(dut_codes[18]), 32'h00);

        // reset after the 3rd accepted code
        fill_gradient();
        start_frame(1'b0, 8'd0);
        n = 0;
        while (frame_acc < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("three codes before reset", 32'(frame_acc >= 3), 32'd1);
        @(posedge clk);
        n = fin_cnt;
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid-frame reset outputs",
              {bus.gray_req, bus.gray_addr, bus.lbp_valid, bus.lbp_addr, bus.lbp_data, bus.finish},
              32'd0);
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("no finish after reset", 32'(fin_cnt - n), 32'd0);
        check("no code after reset", 32'(bus.lbp_valid), 32'd0);
        @(posedge clk);
        #1;
        start_frame(1'b0, 8'd0);
        wait_finish(cyc);
        check("restart first addr", 32'(first_addr), 32'd9);
        check("restart count", 32'(frame_acc), 32'd36);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
